// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, decoder state encoding and event record for the PS/2 key controller
package ps2_pkg;

  // Scan-code prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Decoder states: bit 0 = E0 seen, bit 1 = F0 seen
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_GOT_E0   = 2'b01;
  localparam logic [1:0] ST_GOT_F0   = 2'b10;
  localparam logic [1:0] ST_GOT_E0F0 = 2'b11;

  // One decoded key event as stored in the event FIFO
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - power-of-two event FIFO with simultaneous push/pop even when full
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  ps2_evt_t din,
  input  logic     pop,
  output ps2_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_evt_t       mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_pop;
  logic           do_push;

  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Depth is a power of two, so the top count bit alone means "holding FIFO_DEPTH entries"
  assign full  = count[AW];
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage and pointers; storage is cleared so the head fields read zero out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-byte decoder with held-key tracking, press counter and event FIFO
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       held,
  output logic [7:0] held_code,
  output logic [7:0] press_cnt,
  output logic       overflow,
  output logic       proto_err
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       dec_fire;
  logic       dec_ext;
  logic       dec_brk;
  logic       dec_err;
  logic       held_ext;
  logic       key_match;
  logic       is_repeat;
  logic       push;
  logic       fifo_full;
  logic       fifo_empty;
  ps2_evt_t   ev_in;
  ps2_evt_t   ev_head;

  // Decode one scan byte against the prefix state; a non-prefix byte completes an event
  always_comb begin
    state_nxt = state;
    dec_fire  = 1'b0;
    dec_err   = 1'b0;
    dec_ext   = state[0];
    dec_brk   = state[1];
    if (rx_valid) begin
      if (rx_data == PS2_EXT) begin
        // F0 followed by E0 is illegal; restart as a fresh E0 prefix
        dec_err   = state[1];
        state_nxt = ST_GOT_E0;
      end else if (rx_data == PS2_BRK) begin
        // F0 F0 (with or without E0 before) is illegal; restart as a plain F0 prefix
        dec_err   = state[1];
        state_nxt = state[1] ? ST_GOT_F0 : (state[0] ? ST_GOT_E0F0 : ST_GOT_F0);
      end else begin
        dec_fire  = 1'b1;
        state_nxt = ST_IDLE;
      end
    end
  end

  assign key_match = held && (held_ext == dec_ext) && (held_code == rx_data);
  assign is_repeat = !dec_brk && key_match;
  assign push      = dec_fire && !is_repeat;
  assign ev_in     = '{code: rx_data, ext: dec_ext, brk: dec_brk};

  // Prefix state and the registered protocol-error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      proto_err <= dec_err;
    end
  end

  // Held-key tracking and press counting; typematic repeats of the held key are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held      <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= '0;
      press_cnt <= '0;
    end else if (dec_fire) begin
      if (!dec_brk && !key_match) begin
        held      <= 1'b1;
        held_ext  <= dec_ext;
        held_code <= rx_data;
        press_cnt <= press_cnt + 8'd1;
      end else if (dec_brk && key_match) begin
        held <= 1'b0;
      end
    end
  end

  // Sticky drop flag: full FIFO with no pop this cycle loses the event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (push && fifo_full && !ev_ready) overflow <= 1'b1;
  end

  ps2_evt_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (ev_in),
    .pop  (ev_ready),
    .dout (ev_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = ev_head.code;
  assign ev_ext   = ev_head.ext;
  assign ev_break = ev_head.brk;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - scoreboard bench for ps2_key_ctrl with a prefix-flag reference model
module tb_ps2_key_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ev_ready = 1'b1;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       held;
  logic [7:0] held_code;
  logic [7:0] press_cnt;
  logic       overflow;
  logic       proto_err;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .held(held), .held_code(held_code), .press_cnt(press_cnt),
    .overflow(overflow), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;
  int n_pop = 0;
  int n_err_seen = 0;

  // expected events {code, ext, brk} accepted into the FIFO, oldest first
  logic [9:0] exp_q[$];

  // reference model: pending-prefix flags plus key/count bookkeeping
  bit         m_ext, m_brk, m_held, m_held_ext, m_ovf, m_err;
  logic [7:0] m_held_code, m_cnt;
  int         m_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: consume the byte the DUT samples on this edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ext = 0; m_brk = 0; m_held = 0; m_held_ext = 0; m_ovf = 0; m_err = 0;
      m_held_code = 8'h00; m_cnt = 8'h00; m_occ = 0;
      exp_q.delete();
    end else begin
      bit         pop, have_ev;
      logic [9:0] ev;
      pop = ev_ready && (m_occ > 0);
      have_ev = 0;
      m_err = 0;
      ev = '0;
      if (rx_valid) begin
        if (rx_data == 8'hE0) begin
          if (m_brk) m_err = 1;
          m_ext = 1; m_brk = 0;
        end else if (rx_data == 8'hF0) begin
          if (m_brk) begin m_err = 1; m_ext = 0; end
          m_brk = 1;
        end else begin
          bit same;
          same = m_held && (m_held_ext == m_ext) && (m_held_code == rx_data);
          if (!m_brk) begin
            if (!same) begin
              have_ev = 1; ev = {rx_data, m_ext, 1'b0};
              m_cnt = m_cnt + 8'd1;
              m_held = 1; m_held_ext = m_ext; m_held_code = rx_data;
            end
          end else begin
            have_ev = 1; ev = {rx_data, m_ext, 1'b1};
            if (same) m_held = 0;
          end
          m_ext = 0; m_brk = 0;
        end
      end
      if (have_ev) begin
        if (m_occ < DEPTH || pop) begin
          exp_q.push_back(ev);
          m_occ++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_occ--;
    end
  end

  // monitor: compare DUT outputs mid-cycle and retire accepted events
  always @(negedge clk) begin
    if (!reset) begin
      chk("ev_valid", ev_valid, exp_q.size() != 0);
      if (ev_valid && exp_q.size() != 0) chk("ev_head", {ev_code, ev_ext, ev_break}, exp_q[0]);
      if (ev_valid && ev_ready) begin
        n_pop++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      chk("held", held, m_held);
      chk("held_code", held_code, m_held_code);
      chk("press_cnt", press_cnt, m_cnt);
      chk("overflow", overflow, m_ovf);
      chk("proto_err", proto_err, m_err);
      if (proto_err) n_err_seen++;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ev_valid"}, ev_valid, 0);
    chk({tag, "_ev_fields"}, {ev_code, ev_ext, ev_break}, 0);
    chk({tag, "_held"}, held, 0);
    chk({tag, "_held_code"}, held_code, 0);
    chk({tag, "_press_cnt"}, press_cnt, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    n_pop = 0;
    n_err_seen = 0;
  endtask

  initial begin
    logic [7:0] codes [4];
    codes[0] = 8'h1C; codes[1] = 8'h75; codes[2] = 8'h32; codes[3] = 8'h5A;

    repeat (2) @(posedge clk);
    #1 check_zero("init");
    @(posedge clk); #1;
    reset = 1'b0;

    // case 1: press then release
    send(8'h1C); send(8'hF0); send(8'h1C); idle(4);
    chk("c1_press_cnt", press_cnt, 1);
    chk("c1_held", held, 0);
    chk("c1_events", n_pop, 2);

    // case 2: typematic repeats collapse to one press
    do_reset();
    repeat (5) send(8'h1C);
    send(8'hF0); send(8'h1C); idle(4);
    chk("c2_events", n_pop, 2);
    chk("c2_press_cnt", press_cnt, 1);

    // case 3: extended key, then the plain key with the same code
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h75); idle(4);
    chk("c3_events", n_pop, 3);
    chk("c3_press_cnt", press_cnt, 2);

    // case 4: overflow with consumer stalled, then drain
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h11 + 8'(i));
    idle(2);
    chk("c4_overflow", overflow, 1);
    chk("c4_press_cnt", press_cnt, 6);
    chk("c4_ev_valid", ev_valid, 1);
    ev_ready = 1'b1;
    idle(8);
    chk("c4_drained", n_pop, 4);

    // case 5: F0 F0 is a protocol error, then a plain break
    do_reset();
    send(8'hF0); send(8'hF0); send(8'h1C); idle(4);
    chk("c5_proto_pulses", n_err_seen, 1);
    chk("c5_events", n_pop, 1);

    // case 5b: 256 press/release pairs wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'h1C); send(8'hF0); send(8'h1C);
    end
    idle(4);
    chk("c5b_press_cnt", press_cnt, 0);
    chk("c5b_events", n_pop, 512);

    // case 6: reset in the middle of an E0 F0 prefix with state built up
    do_reset();
    ev_ready = 1'b0;
    send(8'h2A); send(8'hE0); send(8'hF0);
    chk("c6_pre_held", held, 1);
    do_reset();
    ev_ready = 1'b1;
    send(8'h1C); idle(4);
    chk("c6_events", n_pop, 1);
    chk("c6_held_code", held_code, 8'h1C);

    // randomized traffic with random backpressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      ev_ready = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 9) < 7);
      if (r < 12)      rx_data = 8'hE0;
      else if (r < 27) rx_data = 8'hF0;
      else             rx_data = codes[$urandom_range(0, 3)];
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: rx_valid  input  1  one-cycle strobe; a parity- and frame-checked scan byte is on rx_data.
REQ-005 Port: rx_data  input  8  received scan byte.
REQ-006 Port: ev_valid  output  1  event FIFO non-empty.
REQ-007 Port: ev_ready  input  1  consumer accepts the head event when ev_valid && ev_ready.
REQ-008 Port: ev_code  output  8  head event scan code, prefix bytes stripped.
REQ-009 Port: ev_ext  output  1  head event was E0-prefixed.
REQ-010 Port: ev_break  output  1  head event is a release (1) or a press (0).
REQ-011 Port: held  output  1  a key is currently held (the seg_en equivalent).
REQ-012 Port: held_code  output  8  code of the held key; keeps its last value when held=0.
REQ-013 Port: press_cnt  output  8  count of distinct new presses.
REQ-014 Port: overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-015 Port: proto_err  output  1  one-cycle pulse on an illegal prefix sequence.

Function
REQ-016 Decoder FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. The FSM advances only on rx_valid.
REQ-017 IDLE transitions: E0->GOT_E0; F0->GOT_F0; any other byte -> make event (ext=0), stay in IDLE.
REQ-018 GOT_E0 transitions: F0->GOT_E0F0; E0->stay in GOT_E0; other byte -> make event (ext=1), then IDLE.
REQ-019 GOT_F0 transitions: other byte -> break event (ext=0), then IDLE; E0 or F0 -> proto_err pulse, then GOT_E0 or GOT_F0 respectively.
REQ-020 GOT_E0F0 transitions: other byte -> break event (ext=1), then IDLE; E0 or F0 -> proto_err pulse, then GOT_E0 or GOT_F0 respectively.
REQ-021 Make where held=1 and {held_ext, held_code} equals the incoming key is a typematic repeat: no event, no count change.
REQ-022 Any other make: push a press event, press_cnt+1 (wraps 255->0), held<=1, and held_code/held_ext <= the incoming key.
REQ-023 Break matching the held key: push a release event and set held<=0. Break of any other key: push a release event; held is unchanged.
REQ-024 Latency: the event is at the FIFO tail, and ev_valid=1 if the FIFO was empty, in the cycle after the rx_valid of the final byte.
REQ-025 FIFO: first-in first-out. ev_code/ev_ext/ev_break show the head entry and are stable while ev_valid && !ev_ready.
REQ-026 Push while full with no pop in the same cycle: the event is dropped and overflow<=1. held and press_cnt still update.
REQ-027 Push and pop in the same cycle: both take effect, including when the FIFO is full (occupancy unchanged, no overflow).
REQ-028 rx_valid is never stalled; the block accepts one byte per cycle.

Reset
REQ-029 Asserting reset immediately, without waiting for clk, sets: FSM=IDLE, FIFO empty, ev_valid=0, held=0, held_code=0, press_cnt=0, overflow=0, proto_err=0.
REQ-030 Reset asserted in the middle of a prefix sequence discards the partial sequence. The first byte after reset release is decoded from IDLE.

Structure
REQ-031 Package ps2_pkg holds: the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0, the decoder state encoding, and the event record {code[7:0], ext, brk}.
REQ-032 The event FIFO is the sub-module ps2_evt_fifo (parameter FIFO_DEPTH; push/pop/full/empty; same clk and reset).
REQ-033 The RTL has no initial blocks and no latches. The implementation targets 120-400 lines.

Verification
REQ-034 Case 1: feed 1C, F0, 1C with ev_ready=1 -> events {1C,ext0,brk0} then {1C,ext0,brk1}; press_cnt=1; held=0.
REQ-035 Case 2: feed 1C x5 (typematic repeat), then F0, 1C -> exactly 2 events; press_cnt=1.
REQ-036 Case 3: feed E0, 75, E0, F0, 75 -> events {75,ext1,brk0} then {75,ext1,brk1}. A following plain 75 counts as a new press (press_cnt=2).
REQ-037 Case 4: ev_ready=0, FIFO_DEPTH=4, feed 6 distinct makes -> 4 events held, overflow=1, press_cnt=6; draining yields the first 4 codes in order.
REQ-038 Case 5: feed F0, F0, 1C -> one proto_err pulse, then one break event {1C,ext0,brk1}. Separately, 256 distinct press/release pairs -> press_cnt wraps to 0.
REQ-039 Case 6: feed E0, F0, assert reset asynchronously mid-cycle, release it, then feed 1C -> all outputs are zero during reset, then one make event {1C,ext0,brk0}.
